// File: rtl/time_cmd_parser.sv
// time_cmd_parser: ASCII "HH:MM:SS\n" style command parser feeding the clock
// counter's parallel load port. Collects NUM_FIELDS two-digit decimal fields
// (separators optional), validates length and per-field range, and publishes
// a BCD word with a one-cycle load pulse. Rejected commands raise a one-cycle
// err pulse with err_code; load_digits is untouched on error.
//
// Optional build macro: TIME_CMD_ECHO_EN adds a single-entry ack channel
// (tx_data/tx_valid/tx_ready) that queues 'K' on load and 'E' on err.
//
// state   | meaning
// --------+-------------------------------------------------------------
// COLLECT | accepting digits/separators, terminator validates the command
// DISCARD | command already rejected, drop bytes until the terminator
module time_cmd_parser #(
    parameter int          NUM_FIELDS = 3,
    parameter int          FIELD0_MAX = 23,
    parameter int          FIELDN_MAX = 59,
    parameter logic [7:0]  SEP_CHAR   = 8'h3A,
    parameter logic [7:0]  TERM_CHAR  = 8'h0A
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [7:0]              rx_data,
    input  logic                    rx_valid,
    output logic                    load,
    output logic [8*NUM_FIELDS-1:0] load_digits,
    output logic                    err,
    output logic [1:0]              err_code,
    output logic                    busy
`ifdef TIME_CMD_ECHO_EN
    ,
    output logic [7:0]              tx_data,
    output logic                    tx_valid,
    input  logic                    tx_ready
`endif
);

    localparam int SHADOW_W = 8 * NUM_FIELDS;
    localparam int CNT_W    = $clog2(2 * NUM_FIELDS + 1);
    localparam logic [CNT_W-1:0] DIGITS = CNT_W'(2 * NUM_FIELDS);

    localparam logic [1:0] ERR_CHAR  = 2'd1;
    localparam logic [1:0] ERR_LEN   = 2'd2;
    localparam logic [1:0] ERR_RANGE = 2'd3;

    localparam logic [7:0] CR_CHAR = 8'h0D;

    typedef enum logic {
        COLLECT = 1'b0,
        DISCARD = 1'b1
    } state_t;

    state_t                state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [SHADOW_W-1:0]   shadow_q, shadow_d;
    logic [SHADOW_W-1:0]   load_digits_q, load_digits_d;
    logic                  load_q, load_d;
    logic                  err_q, err_d;
    logic [1:0]            err_code_q, err_code_d;

    logic                  is_digit;
    logic                  range_ok;
    logic [3:0]            f_tens;
    logic [3:0]            f_ones;
    logic [6:0]            f_val;
    logic [6:0]            f_max;

    assign is_digit = (rx_data >= 8'h30) && (rx_data <= 8'h39);

    // Range check of every field from the registered shadow; the terminator
    // always follows the last digit, so no forwarding of the incoming byte.
    always_comb begin
        range_ok = 1'b1;
        f_tens   = 4'd0;
        f_ones   = 4'd0;
        f_val    = 7'd0;
        f_max    = 7'd0;
        for (int f = 0; f < NUM_FIELDS; f++) begin
            f_tens = shadow_q[SHADOW_W-1-8*f -: 4];
            f_ones = shadow_q[SHADOW_W-5-8*f -: 4];
            f_val  = ({3'b000, f_tens} * 7'd10) + {3'b000, f_ones};
            f_max  = (f == 0) ? 7'(FIELD0_MAX) : 7'(FIELDN_MAX);
            if (f_val > f_max) begin
                range_ok = 1'b0;
            end
        end
    end

    // Next-state, shadow capture and pulse generation per received byte.
    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        shadow_d      = shadow_q;
        load_digits_d = load_digits_q;
        load_d        = 1'b0;
        err_d         = 1'b0;
        err_code_d    = err_code_q;

        if (rx_valid) begin
            unique case (state_q)
                COLLECT: begin
                    if (is_digit) begin
                        if (cnt_q < DIGITS) begin
                            for (int k = 0; k < 2 * NUM_FIELDS; k++) begin
                                if (cnt_q == CNT_W'(k)) begin
                                    shadow_d[SHADOW_W-1-4*k -: 4] = rx_data[3:0];
                                end
                            end
                            cnt_d = cnt_q + CNT_W'(1);
                        end else begin
                            err_d      = 1'b1;
                            err_code_d = ERR_LEN;
                            state_d    = DISCARD;
                        end
                    end else if (rx_data == TERM_CHAR) begin
                        cnt_d = '0;
                        if (cnt_q != DIGITS) begin
                            err_d      = 1'b1;
                            err_code_d = ERR_LEN;
                        end else if (!range_ok) begin
                            err_d      = 1'b1;
                            err_code_d = ERR_RANGE;
                        end else begin
                            load_d        = 1'b1;
                            load_digits_d = shadow_q;
                        end
                    end else if (rx_data == SEP_CHAR) begin
                        // Separators are only legal on a field boundary
                        // between two fields.
                        if (!(cnt_q[0] == 1'b0 && cnt_q != '0 && cnt_q < DIGITS)) begin
                            err_d      = 1'b1;
                            err_code_d = ERR_CHAR;
                            state_d    = DISCARD;
                        end
                    end else if (rx_data == CR_CHAR) begin
                        state_d = COLLECT;
                    end else begin
                        err_d      = 1'b1;
                        err_code_d = ERR_CHAR;
                        state_d    = DISCARD;
                    end
                end
                DISCARD: begin
                    if (rx_data == TERM_CHAR) begin
                        state_d = COLLECT;
                        cnt_d   = '0;
                    end
                end
                default: begin
                    state_d = COLLECT;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    // Parser registers; reset wins over a byte arriving in the same cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= COLLECT;
            cnt_q         <= '0;
            shadow_q      <= '0;
            load_digits_q <= '0;
            load_q        <= 1'b0;
            err_q         <= 1'b0;
            err_code_q    <= 2'd0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            shadow_q      <= shadow_d;
            load_digits_q <= load_digits_d;
            load_q        <= load_d;
            err_q         <= err_d;
            err_code_q    <= err_code_d;
        end
    end

    assign load        = load_q;
    assign load_digits = load_digits_q;
    assign err         = err_q;
    assign err_code    = err_code_q;
    assign busy        = (cnt_q != '0) || (state_q == DISCARD);

`ifdef TIME_CMD_ECHO_EN
    logic       tx_valid_q, tx_valid_d;
    logic [7:0] tx_data_q, tx_data_d;

    // Single-entry ack holder; a newer ack overwrites a pending one.
    always_comb begin
        tx_valid_d = tx_valid_q;
        tx_data_d  = tx_data_q;
        if (load_d) begin
            tx_valid_d = 1'b1;
            tx_data_d  = 8'h4B;
        end else if (err_d) begin
            tx_valid_d = 1'b1;
            tx_data_d  = 8'h45;
        end else if (tx_valid_q && tx_ready) begin
            tx_valid_d = 1'b0;
        end
    end

    // Ack holding register.
    always_ff @(posedge clk) begin
        if (reset) begin
            tx_valid_q <= 1'b0;
            tx_data_q  <= 8'h00;
        end else begin
            tx_valid_q <= tx_valid_d;
            tx_data_q  <= tx_data_d;
        end
    end

    assign tx_valid = tx_valid_q;
    assign tx_data  = tx_data_q;
`endif

endmodule

// File: tb/tb_time_cmd_parser.sv
// Scoreboard bench for time_cmd_parser (default parameters, 3 fields).
// Each command names the byte that should trigger a load or err; the
// expectation is queued as that byte is driven and popped by the monitor.
module tb_time_cmd_parser;

    logic        clk;
    logic        reset;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        load;
    logic [23:0] load_digits;
    logic        err;
    logic [1:0]  err_code;
    logic        busy;
`ifdef TIME_CMD_ECHO_EN
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;
`endif

    time_cmd_parser dut (
        .clk        (clk),
        .reset      (reset),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .load       (load),
        .load_digits(load_digits),
        .err        (err),
        .err_code   (err_code),
        .busy       (busy)
`ifdef TIME_CMD_ECHO_EN
        ,
        .tx_data    (tx_data),
        .tx_valid   (tx_valid),
        .tx_ready   (tx_ready)
`endif
    );

    typedef struct {
        bit          is_load;
        logic [23:0] digits;
        logic [1:0]  code;
    } exp_t;

    exp_t        exp_q[$];
    int          n_checks = 0;
    int          n_errors = 0;
    logic [23:0] last_good = 24'h0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Monitor: every load/err pulse must match the oldest queued expectation.
    always @(negedge clk) begin
        exp_t e;
        if (!reset && (load || err)) begin
            if (exp_q.size() == 0) begin
                check("unexpected_event", {30'd0, load, err}, 32'd0);
            end else begin
                e = exp_q.pop_front();
                check("event_is_load", {31'd0, load}, {31'd0, e.is_load});
                check("event_is_err", {31'd0, err}, {31'd0, !e.is_load});
                if (e.is_load) begin
                    check("load_digits", {8'd0, load_digits}, {8'd0, e.digits});
                    last_good = e.digits;
`ifdef TIME_CMD_ECHO_EN
                    check("tx_ack_k", {23'd0, tx_valid, tx_data}, {23'd0, 1'b1, 8'h4B});
`endif
                end else begin
                    check("err_code", {30'd0, err_code}, {30'd0, e.code});
                    check("digits_kept", {8'd0, load_digits}, {8'd0, last_good});
`ifdef TIME_CMD_ECHO_EN
                    check("tx_ack_e", {23'd0, tx_valid, tx_data}, {23'd0, 1'b1, 8'h45});
`endif
                end
            end
        end
    end

    // Drive a command back-to-back; trig is the index of the byte that
    // should produce the event (-1: none expected).
    task automatic send_cmd(input string s, input int trig, input bit is_load,
                            input logic [23:0] dig, input logic [1:0] code);
        exp_t e;
        for (int i = 0; i < s.len(); i++) begin
            @(posedge clk);
            #1;
            if (i == trig) begin
                e.is_load = is_load;
                e.digits  = dig;
                e.code    = code;
                exp_q.push_back(e);
            end
            rx_data  = s[i];
            rx_valid = 1'b1;
        end
        @(posedge clk);
        #1;
        rx_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check({"drain ", s}, exp_q.size(), 32'd0);
        exp_q.delete();
    endtask

    initial begin
        reset    = 1'b1;
        rx_data  = 8'h00;
        rx_valid = 1'b0;
`ifdef TIME_CMD_ECHO_EN
        tx_ready = 1'b1;
`endif
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        check("rst_load", {31'd0, load}, 32'd0);
        check("rst_err", {31'd0, err}, 32'd0);
        check("rst_err_code", {30'd0, err_code}, 32'd0);
        check("rst_digits", {8'd0, load_digits}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);

        send_cmd("12:34:56\n", 8, 1'b1, 24'h123456, 2'd0);
        send_cmd("235959\015\n", 7, 1'b1, 24'h235959, 2'd0);
        send_cmd("24:00:00\n", 8, 1'b0, 24'h0, 2'd3);
        check("digits_after_range_err", {8'd0, load_digits}, {8'd0, 24'h235959});
        send_cmd("1:234:56\n", 1, 1'b0, 24'h0, 2'd1);
        check("err_code_held", {30'd0, err_code}, 32'd1);
        send_cmd("01:02:03\n", 8, 1'b1, 24'h010203, 2'd0);
        send_cmd("1234567\n", 6, 1'b0, 24'h0, 2'd2);
        send_cmd("12345\n", 5, 1'b0, 24'h0, 2'd2);
        send_cmd("\n", 0, 1'b0, 24'h0, 2'd2);
        send_cmd("12a\n", 2, 1'b0, 24'h0, 2'd1);
        send_cmd(":12:34:56\n", 0, 1'b0, 24'h0, 2'd1);
        send_cmd("12:34:56:\n", 8, 1'b0, 24'h0, 2'd1);
        send_cmd("23:59:59\n", 8, 1'b1, 24'h235959, 2'd0);
        send_cmd("00:60:00\n", 8, 1'b0, 24'h0, 2'd3);
        send_cmd("00:00:60\n", 8, 1'b0, 24'h0, 2'd3);
        send_cmd("00:59:09\n", 8, 1'b1, 24'h005909, 2'd0);

        // Partial command, then reset with a byte in the same cycle.
        send_cmd("12:3", -1, 1'b0, 24'h0, 2'd0);
        check("busy_partial", {31'd0, busy}, 32'd1);
        @(posedge clk);
        #1;
        reset    = 1'b1;
        rx_data  = 8'h39;
        rx_valid = 1'b1;
        @(posedge clk);
        #1;
        reset    = 1'b0;
        rx_valid = 1'b0;
        last_good = 24'h0;
        @(negedge clk);
        check("busy_after_reset", {31'd0, busy}, 32'd0);
        check("digits_after_reset", {8'd0, load_digits}, 32'd0);
        check("err_code_after_reset", {30'd0, err_code}, 32'd0);
        send_cmd("00:00:01\n", 8, 1'b1, 24'h000001, 2'd0);
        check("busy_idle", {31'd0, busy}, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/time_cmd_parser.md
Name: time_cmd_parser

Overview:
- Parametrised ASCII time-command parser between the UART receiver byte stream and the clock counter's parallel load port.
- Collects NUM_FIELDS two-digit decimal fields, most significant field first, with optional separators.
- Validates length and field ranges, and publishes a complete BCD word with a single-cycle load pulse only when the command is valid.
- Malformed commands are rejected with an error code; the published outputs stay untouched on error.

Parameters:
- NUM_FIELDS, 3, number of two-digit fields (3 = HH MM SS; range 1..4).
- FIELD0_MAX, 23, maximum decimal value of field 0 (hours).
- FIELDN_MAX, 59, maximum decimal value of fields 1..NUM_FIELDS-1.
- SEP_CHAR, 8'h3A, optional field separator (':').
- TERM_CHAR, 8'h0A, command terminator ('\n').

Ports:
- clk  input  1  system clock.
- reset  input  1  synchronous active-high reset.
- rx_data  input  8  received byte, qualified by rx_valid.
- rx_valid  input  1  one-cycle strobe per received byte.
- load  output  1  one-cycle pulse; load_digits is valid in the same cycle.
- load_digits  output  8*NUM_FIELDS  BCD digits. Field 0 tens digit occupies the MSBs; each field is {tens[3:0], ones[3:0]}.
- err  output  1  one-cycle pulse on command rejection.
- err_code  output  2  1 = illegal char, 2 = length, 3 = range; holds its value until the next err.
- busy  output  1  high while a command is partially received (digit count > 0 or state DISCARD).

Behaviour:
- Reset (synchronous): state=COLLECT, cnt=0, load=0, err=0, err_code=0, load_digits=0, shadow buffer=0.
- Per rx_valid byte, in state COLLECT:
  - Digit '0'..'9': if cnt < 2*NUM_FIELDS, store (rx_data-8'h30) in shadow slot cnt and increment cnt. Otherwise err(2), go to DISCARD.
  - SEP_CHAR: accepted only when cnt is even, nonzero and < 2*NUM_FIELDS; no state change. Anywhere else: err(1), go to DISCARD.
  - 8'h0D (CR): ignored.
  - TERM_CHAR:
    - cnt != 2*NUM_FIELDS: err(2).
    - Any field exceeds its max (field value = 10*tens + ones): err(3).
    - Otherwise copy shadow to load_digits and pulse load.
    - In every case cnt returns to 0.
  - Any other byte: err(1), go to DISCARD.
- State DISCARD: ignore every byte except TERM_CHAR. TERM_CHAR returns the block to COLLECT with cnt=0 and raises no further err.
- Latency: load/err assert on the clock edge that samples the triggering byte, i.e. registered one cycle after the rx_valid cycle. Each pulse is exactly one cycle wide.
- load_digits changes only on the load cycle; otherwise it holds the last valid command.
- Consecutive rx_valid on back-to-back cycles must be handled with no byte lost.
- Empty line (TERM_CHAR with cnt=0) in COLLECT: err(2).
- rx_valid asserted in the same cycle as reset: the byte is dropped; reset wins.
- Range check uses only registered shadow digits plus, for the final digit, no forwarding. The terminator arrives after the last digit, so the shadow is complete.

Optional Feature:
- Macro: TIME_CMD_ECHO_EN.
- When defined, add ports tx_data (output 8), tx_valid (output 1) and tx_ready (input 1).
  - On each load, queue ack byte 'K' (8'h4B); on each err, queue 'E' (8'h45).
  - Single-entry holding register: tx_valid stays high until sampled with tx_ready. A new ack arriving while one is pending overwrites it.
  - Reset clears tx_valid.
- When undefined, these ports do not exist and no ack logic is built.

Test Plan:
- "12:34:56\n" → one load pulse, load_digits=24'h123456, err never asserted.
- "235959\r\n" (no separators, CR) → load, load_digits=24'h235959.
- "24:00:00\n" → err, err_code=3, no load, load_digits unchanged from the previous value.
- "1:234:56\n" → err_code=1 at the first ':'; bytes through '\n' discarded. The following "01:02:03\n" loads 24'h010203.
- "1234567\n" → err_code=2 at the 7th digit. "12345\n" → err_code=2 at '\n'. "\n" alone → err_code=2.
- Reset asserted after "12:3" → busy=0 and cnt cleared. A subsequent "00:00:01\n" loads 24'h000001. With TIME_CMD_ECHO_EN and tx_ready=1, tx_data='K' appears for one cycle.
